// File: rtl/ram_master_pkg.sv
// Shared FSM encoding and default widths for the ram_master burst engine.
package ram_master_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_LEN_WIDTH  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/ram_burst_ctr.sv
// Address and beat counter for one burst: loads start address and length,
// steps once per consumed beat and flags the final beat.
module ram_burst_ctr
  import ram_master_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [LEN_WIDTH-1:0]  load_len,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  logic [LEN_WIDTH-1:0] beat;
  logic [LEN_WIDTH-1:0] len_q;

  // Address wraps naturally at 2^ADDR_WIDTH by truncation.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr  <= '0;
      beat  <= '0;
      len_q <= '0;
    end else if (load) begin
      addr  <= load_addr;
      beat  <= '0;
      len_q <= load_len;
    end else if (inc) begin
      addr <= addr + ADDR_WIDTH'(1);
      beat <= beat + LEN_WIDTH'(1);
    end
  end

  assign last = (beat == len_q);

endmodule

// File: rtl/ram_master.sv
// Burst master for a synchronous one-cycle-latency RAM.
// Optional RAM_MASTER_WRAP_ERR_EN: sticky err when a burst wraps the address space.
module ram_master
  import ram_master_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  err,
  output logic                  ram_we,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  state_t                state;
  logic                  accept;
  logic                  inc;
  logic                  last;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  rd_valid_q;

  assign cmd_ready = (state == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign inc       = ((state == WRITE) && wr_valid) || (state == READ);

  ram_burst_ctr #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_addr(cmd_addr),
    .load_len (cmd_len),
    .inc      (inc),
    .addr     (cur_addr),
    .last     (last)
  );

  // rd_valid trails each READ issue cycle by one, matching the RAM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= (state == READ);
      case (state)
        IDLE: begin
          if (accept) state <= cmd_we ? WRITE : READ;
        end
        WRITE: begin
          if (wr_valid && last) state <= IDLE;
        end
        READ: begin
          if (last) state <= DRAIN;
        end
        DRAIN: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign wr_ready = (state == WRITE);
  assign ram_we   = (state == WRITE) && wr_valid;
  assign ram_re   = (state == READ);
  assign ram_addr = ((state == WRITE) || (state == READ)) ? cur_addr : '0;
  assign ram_din  = (state == WRITE) ? wr_data : '0;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_valid_q ? ram_dout : '0;

`ifdef RAM_MASTER_WRAP_ERR_EN
  localparam int SUM_WIDTH = ((ADDR_WIDTH > LEN_WIDTH) ? ADDR_WIDTH : LEN_WIDTH) + 1;

  logic [SUM_WIDTH-1:0] burst_end;
  logic                 err_q;

  // Any carry above the address width means the burst runs past the top address.
  assign burst_end = SUM_WIDTH'(cmd_addr) + SUM_WIDTH'(cmd_len);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept && (|burst_end[SUM_WIDTH-1:ADDR_WIDTH])) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_master.sv
// Directed self-checking bench for ram_master with a behavioural one-cycle RAM.
module tb_ram_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_we;
  logic [3:0] cmd_addr;
  logic [3:0] cmd_len;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       err;
  logic       ram_we;
  logic       ram_re;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout = 8'h00;

  logic [7:0] mem [16];

  int errors = 0;
  int checks = 0;

  logic       exp_err;
  logic [7:0] wpat [3]      = '{8'hAA, 8'hBB, 8'hCC};
  logic       stall_v [4]   = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [7:0] stall_d [4]   = '{8'h11, 8'h00, 8'h00, 8'h22};
  logic [3:0] stall_a [4]   = '{4'h8, 4'h9, 4'h9, 4'h9};
  logic [3:0] wrap_a [4]    = '{4'hE, 4'hF, 4'h0, 4'h1};

  always #5 clk = ~clk;

  ram_master #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .LEN_WIDTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .busy     (busy),
    .err      (err),
    .ram_we   (ram_we),
    .ram_re   (ram_re),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  // Synchronous RAM with registered read data.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    if (ram_re) ram_dout <= mem[ram_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic we, input logic [3:0] a, input logic [3:0] l);
    cmd_valid = v;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_len   = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    checkOutput("we_re_exclusive", 32'(ram_we & ram_re), 32'd0);
  end

  initial begin
`ifdef RAM_MASTER_WRAP_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    tick();
    tick();

    // Reset state while rst is still high.
    checkOutput("rst_cmd_ready", cmd_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_rd_valid", rd_valid, 0);
    checkOutput("rst_ram_we", ram_we, 0);
    checkOutput("rst_ram_re", ram_re, 0);
    checkOutput("rst_ram_addr", ram_addr, 0);
    checkOutput("rst_err", err, 0);
    rst = 1'b0;
    #1;
    checkOutput("rst_cmd_ready_low", cmd_ready, 1);

    // Write burst 0x3 len 2.
    applyStimulus(1'b1, 1'b1, 4'h3, 4'h2);
    wr_valid = 1'b1;
    wr_data  = wpat[0];
    tick();
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      wr_data = wpat[i];
      #1;
      checkOutput("wr_ram_we", ram_we, 1);
      checkOutput("wr_ram_addr", ram_addr, 32'(3 + i));
      checkOutput("wr_ram_din", ram_din, wpat[i]);
      checkOutput("wr_cmd_ready", cmd_ready, 0);
      checkOutput("wr_busy", busy, 1);
      tick();
    end
    wr_valid = 1'b0;
    #1;
    checkOutput("wr_done_cmd_ready", cmd_ready, 1);
    checkOutput("wr_done_busy", busy, 0);
    checkOutput("wr_done_err", err, 0);

    // Read burst 0x3 len 2.
    applyStimulus(1'b1, 1'b0, 4'h3, 4'h2);
    tick();
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
    for (int c = 1; c <= 5; c++) begin
      checkOutput("rd_ram_re", ram_re, (c <= 3) ? 1 : 0);
      checkOutput("rd_ram_addr", ram_addr, (c <= 3) ? 32'(2 + c) : 0);
      checkOutput("rd_valid", rd_valid, (c >= 2 && c <= 4) ? 1 : 0);
      if (c >= 2 && c <= 4) checkOutput("rd_data", rd_data, wpat[c - 2]);
      checkOutput("rd_cmd_ready", cmd_ready, (c == 5) ? 1 : 0);
      checkOutput("rd_busy", busy, (c <= 4) ? 1 : 0);
      tick();
    end

    // Write with wr_valid stalls between beats.
    applyStimulus(1'b1, 1'b1, 4'h8, 4'h1);
    tick();
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
    for (int c = 0; c < 4; c++) begin
      wr_valid = stall_v[c];
      wr_data  = stall_d[c];
      #1;
      checkOutput("stall_ram_we", ram_we, stall_v[c]);
      checkOutput("stall_ram_addr", ram_addr, stall_a[c]);
      checkOutput("stall_busy", busy, 1);
      checkOutput("stall_wr_ready", wr_ready, 1);
      tick();
    end
    wr_valid = 1'b0;
    #1;
    checkOutput("stall_done_busy", busy, 0);
    checkOutput("stall_mem8", mem[8], 8'h11);
    checkOutput("stall_mem9", mem[9], 8'h22);

    // Write wrapping past the top address.
    applyStimulus(1'b1, 1'b1, 4'hE, 4'h3);
    wr_valid = 1'b1;
    tick();
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      wr_data = 8'(i + 1);
      #1;
      checkOutput("wrap_ram_addr", ram_addr, wrap_a[i]);
      checkOutput("wrap_err", err, exp_err);
      tick();
    end
    wr_valid = 1'b0;
    #1;
    checkOutput("wrap_err_sticky", err, exp_err);
    checkOutput("wrap_busy", busy, 0);
    checkOutput("wrap_memE", mem[14], 8'h01);
    checkOutput("wrap_memF", mem[15], 8'h02);
    checkOutput("wrap_mem0", mem[0], 8'h03);
    checkOutput("wrap_mem1", mem[1], 8'h04);

    // Reset during beat 2 of a 4-beat read.
    applyStimulus(1'b1, 1'b0, 4'h0, 4'h3);
    tick();
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
    checkOutput("rrst_ram_re1", ram_re, 1);
    checkOutput("rrst_ram_addr1", ram_addr, 0);
    tick();
    checkOutput("rrst_rd_valid2", rd_valid, 1);
    checkOutput("rrst_rd_data2", rd_data, 8'h03);
    rst = 1'b1;
    tick();
    checkOutput("rrst_busy", busy, 0);
    checkOutput("rrst_ram_re", ram_re, 0);
    checkOutput("rrst_rd_valid", rd_valid, 0);
    checkOutput("rrst_rd_data", rd_data, 0);
    checkOutput("rrst_cmd_ready", cmd_ready, 0);
    checkOutput("rrst_err", err, 0);
    rst = 1'b0;
    #1;
    checkOutput("rrst_cmd_ready_low", cmd_ready, 1);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("rrst_no_rd_valid", rd_valid, 0);
      checkOutput("rrst_idle", busy, 0);
    end

    // cmd_valid held high across a burst.
    applyStimulus(1'b1, 1'b1, 4'h5, 4'h1);
    wr_valid = 1'b1;
    wr_data  = 8'h55;
    tick();
    applyStimulus(1'b1, 1'b0, 4'h5, 4'h0);
    #1;
    checkOutput("hold_cmd_ready1", cmd_ready, 0);
    checkOutput("hold_ram_we1", ram_we, 1);
    checkOutput("hold_ram_addr1", ram_addr, 4'h5);
    tick();
    wr_data = 8'h66;
    #1;
    checkOutput("hold_cmd_ready2", cmd_ready, 0);
    checkOutput("hold_ram_addr2", ram_addr, 4'h6);
    checkOutput("hold_busy2", busy, 1);
    tick();
    checkOutput("hold_cmd_ready3", cmd_ready, 1);
    checkOutput("hold_ram_we3", ram_we, 0);
    tick();
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
    wr_valid = 1'b0;
    #1;
    checkOutput("hold_ram_re4", ram_re, 1);
    checkOutput("hold_ram_addr4", ram_addr, 4'h5);
    tick();
    checkOutput("hold_rd_valid5", rd_valid, 1);
    checkOutput("hold_rd_data5", rd_data, 8'h55);
    tick();
    checkOutput("hold_cmd_ready6", cmd_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_master.md
RAM_MASTER -- requirements
Module: ram_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: RAM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: RAM address width.
REQ-003 SHALL have parameter LEN_WIDTH, default 4: burst length field width; a burst is cmd_len+1 beats.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port cmd_valid  input  1  command offered.
REQ-007 SHALL have port cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at a rising edge.
REQ-008 SHALL have port cmd_we  input  1  1 = write burst, 0 = read burst.
REQ-009 SHALL have port cmd_addr  input  ADDR_WIDTH  burst start address.
REQ-010 SHALL have port cmd_len  input  LEN_WIDTH  beats minus one.
REQ-011 SHALL have port wr_data  input  DATA_WIDTH  write beat data.
REQ-012 SHALL have port wr_valid  input  1  write beat offered.
REQ-013 SHALL have port wr_ready  output  1  write beat consumed when wr_valid & wr_ready.
REQ-014 SHALL have port rd_data  output  DATA_WIDTH  read beat data, valid with rd_valid.
REQ-015 SHALL have port rd_valid  output  1  read beat strobe, no backpressure.
REQ-016 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-017 SHALL have port err  output  1  sticky address-wrap flag (see Configuration).
REQ-018 SHALL have ports ram_we, ram_re (output, 1), ram_addr (output, ADDR_WIDTH), ram_din (output, DATA_WIDTH), ram_dout (input, DATA_WIDTH): connection to a synchronous RAM with one-cycle registered read.

Function
REQ-019 SHALL implement FSM states IDLE, WRITE, READ, DRAIN.
REQ-020 SHALL drive cmd_ready high only in IDLE; on accept, latch cmd_addr/cmd_len/cmd_we and go to WRITE or READ.
REQ-021 In WRITE, SHALL drive wr_ready=1, ram_we=wr_valid, ram_addr=current address, ram_din=wr_data (combinational); wr_valid low stalls with no RAM write.
REQ-022 In READ, SHALL drive ram_re=1 every cycle with ram_addr=current address, no stalls.
REQ-023 SHALL advance current address by 1 per consumed beat, modulo 2^ADDR_WIDTH (0xF wraps to 0x0 at default width).
REQ-024 SHALL return WRITE to IDLE after the beat with beat count cmd_len+1 is consumed.
REQ-025 SHALL go READ to DRAIN after cmd_len+1 issue cycles, DRAIN to IDLE after one cycle.
REQ-026 SHALL assert rd_valid exactly one cycle after each ram_re cycle, with rd_data=ram_dout in that cycle.
REQ-027 Read latency: accept at edge 0, ram_re cycles 1..N, rd_valid cycles 2..N+1, cmd_ready high again in cycle N+2 (N = cmd_len+1).
REQ-028 SHALL never assert ram_we and ram_re in the same cycle.
REQ-029 SHALL ignore wr_valid outside WRITE and cmd_valid outside IDLE.

Reset
REQ-030 SHALL, on any edge with rst high, enter IDLE, clear beat counter, address, rd_valid and err.
REQ-031 SHALL hold cmd_ready, wr_ready, ram_we, ram_re, rd_valid, busy, err at 0 and ram_addr, ram_din, rd_data at 0 in the cycle after a reset edge, except cmd_ready, which is 1 once rst is low.
REQ-032 Reset mid-burst SHALL abandon the burst; no pending rd_valid is emitted afterwards.

Configuration
REQ-033 Macro RAM_MASTER_WRAP_ERR_EN defined: err set on accept when cmd_addr+cmd_len > 2^ADDR_WIDTH-1, held until rst; burst still executes with wrap.
REQ-034 Macro undefined: err tied to 0, wrap silent, no wrap-detect logic present.

Structure
REQ-035 SHALL place the FSM state encoding and default width constants in shared package ram_master_pkg.
REQ-036 SHALL place address/beat counter in sub-module ram_burst_ctr (load, increment, last-beat flag).

Verification
REQ-037 Write addr 0x3 len 2 data AA,BB,CC, wr_valid constant -> ram_we 3 cycles at 0x3,0x4,0x5, cmd_ready back the cycle after.
REQ-038 Read addr 0x3 len 2 after REQ-037 -> rd_valid cycles 2-4 with AA,BB,CC; cmd_ready in cycle 5.
REQ-039 Write len 1 with wr_valid low 2 cycles between beats -> no ram_we while low, both beats written, busy high throughout.
REQ-040 Write addr 0xE len 3 -> writes at 0xE,0xF,0x0,0x1; err=1 with RAM_MASTER_WRAP_ERR_EN, err=0 without.
REQ-041 rst pulsed during beat 2 of a 4-beat read -> next cycle IDLE, no further rd_valid, cmd_ready=1 after rst drops.
REQ-042 cmd_valid held high throughout a burst -> second command accepted only in IDLE, never mid-burst.
